// File: rtl/serial_pkg.sv
// Shared definitions for the serial transmit/receive path.
package serial_pkg;

  // Byte width shared by the FIFO, send_serial and the receiver.
  localparam int unsigned BYTE_W = 8;

  // Issue FSM states for serial_tx_fifo.
  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ISSUE      = 2'd1,
    WAIT_START = 2'd2,
    WAIT_DONE  = 2'd3
  } tx_fifo_state_t;

endpackage : serial_pkg

// File: rtl/serial_tx_fifo_sync_fifo.sv
// Byte FIFO. It holds the storage, the pointers, the occupancy count and the
// sticky overflow flag. The read data is the head entry, shown as a
// combinational value, and the read side pops it with rd_en.
module sync_fifo
  import serial_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [BYTE_W-1:0]       wr_data,
  input  logic                    wr_en,
  input  logic                    rd_en,
  output logic [BYTE_W-1:0]       rd_data,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow,
  input  logic                    clr_ovf
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [BYTE_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              push, pop;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign overflow = ovf_q;
  assign rd_data  = mem_q[rd_ptr_q];

  // A push is refused while full, even when a pop happens in the same cycle.
  always_comb begin
    push = wr_en && !full;
    pop  = rd_en && !empty;
  end

  // Next state for the pointers, the occupancy count and the sticky overflow.
  // A new overflow event wins over a clear in the same cycle.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (wr_en && full) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end
  end

  // Storage array. It is not reset, because the count makes stale entries unreachable.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  // Registers for the pointers, the count and the overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

endmodule : sync_fifo

// File: rtl/serial_tx_fifo.sv
// Transmit FIFO with an issue FSM, placed in front of the UART transmitter.
// It issues one byte with a single-cycle tx_we strobe. It then waits for
// tx_busy to rise and fall before it takes the next byte. If busy never rises
// within START_TMO cycles, the byte is dropped.
module serial_tx_fifo
  import serial_pkg::*;
#(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned START_TMO = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [BYTE_W-1:0]       wr_data,
  input  logic                    wr_en,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow,
  input  logic                    clr_ovf,
  output logic [BYTE_W-1:0]       tx_data,
  output logic                    tx_we,
  input  logic                    tx_busy
);

  localparam int unsigned TMO_W = $clog2(START_TMO + 1);

  tx_fifo_state_t     state_q, state_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [BYTE_W-1:0]  tx_data_q, tx_data_d;
  logic               tx_we_q, tx_we_d;
  logic               pop;
  logic [BYTE_W-1:0]  head;

  sync_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_data  (wr_data),
    .wr_en    (wr_en),
    .rd_en    (pop),
    .rd_data  (head),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow),
    .clr_ovf  (clr_ovf)
  );

  assign tx_data = tx_data_q;
  assign tx_we   = tx_we_q;

  // Issue FSM next state. tx_we is registered on the IDLE->ISSUE edge, so the
  // strobe lines up with the ISSUE cycle and the output has no glitches.
  always_comb begin
    state_d   = state_q;
    tmo_d     = tmo_q;
    tx_data_d = tx_data_q;
    tx_we_d   = 1'b0;
    pop       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          tx_data_d = head;
          tx_we_d   = 1'b1;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        tmo_d   = '0;
        state_d = WAIT_START;
      end
      WAIT_START: begin
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end else if (tmo_q == TMO_W'(START_TMO - 1)) begin
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, timeout counter and registered transmitter-facing outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      tmo_q     <= '0;
      tx_data_q <= '0;
      tx_we_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmo_q     <= tmo_d;
      tx_data_q <= tx_data_d;
      tx_we_q   <= tx_we_d;
    end
  end

endmodule : serial_tx_fifo

// File: tb/tb_serial_tx_fifo.sv
// Scoreboard bench for serial_tx_fifo. The stimulus queues the expected bytes.
// A monitor on the falling edge checks every tx_we issue, the occupancy and the
// issue spacing. A small process models the transmitter's busy pulse.
module tb_serial_tx_fifo;

  localparam int DEPTH     = 16;
  localparam int START_TMO = 4;

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b1;
  logic [7:0] wr_data = '0;
  logic       wr_en   = 1'b0;
  logic       full, empty, overflow;
  logic [4:0] count;
  logic       clr_ovf = 1'b0;
  logic [7:0] tx_data;
  logic       tx_we;
  logic       tx_busy = 1'b0;

  serial_tx_fifo #(
    .DEPTH     (DEPTH),
    .START_TMO (START_TMO)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_data  (wr_data),
    .wr_en    (wr_en),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow),
    .clr_ovf  (clr_ovf),
    .tx_data  (tx_data),
    .tx_we    (tx_we),
    .tx_busy  (tx_busy)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] exp_q[$];
  bit         push_flag = 1'b0;
  bit         edge_push = 1'b0;
  int         model_cnt = 0;
  int         busy_len  = 0;
  int         bl;
  int         cyc = 0;
  int         we_total = 0;
  bit         prev_we = 1'b0;
  bit         gap_chk = 1'b0;
  int         last_we_cyc = -1;
  int         last_busy = 0;
  logic [7:0] e_byte;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Latch whether the stimulus offered an accepted push at this edge.
  initial forever begin
    @(posedge clk);
    edge_push = push_flag;
  end

  // Transmitter model. Busy rises the cycle after tx_we and stays high for busy_len cycles.
  initial forever begin
    @(negedge clk);
    if (rst_n && tx_we && busy_len > 0) begin
      bl = busy_len;
      @(posedge clk);
      #1 tx_busy = 1'b1;
      repeat (bl) @(posedge clk);
      #1 tx_busy = 1'b0;
    end
  end

  // Monitor. Occupancy model, issue scoreboard and protocol checks.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      prev_we     = 1'b0;
      last_we_cyc = -1;
    end else begin
      cyc++;
      model_cnt = model_cnt + int'(edge_push) - int'(tx_we);
      chk("count", 32'(count), 32'(model_cnt));
      chk("empty", 32'(empty), 32'(model_cnt == 0));
      chk("full", 32'(full), 32'(model_cnt == DEPTH));
      if (tx_we) begin
        we_total++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL tx_we_unexpected: got issue of 0x%0h, expected no issue (t=%0t)", tx_data, $time);
        end else begin
          e_byte = exp_q.pop_front();
          chk("tx_data", 32'(tx_data), 32'(e_byte));
        end
        chk("we_while_busy", 32'(tx_busy), 32'd0);
        chk("we_consecutive", 32'(prev_we), 32'd0);
        if (gap_chk && last_we_cyc >= 0)
          chk("issue_gap", 32'(cyc - last_we_cyc),
              32'((last_busy == 0) ? START_TMO + 2 : last_busy + 3));
        last_we_cyc = cyc;
        last_busy   = busy_len;
      end
      prev_we = tx_we;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      step();
      wr_en     = 1'b0;
      push_flag = 1'b0;
      clr_ovf   = 1'b0;
    end
  endtask

  task automatic push_retry(input logic [7:0] b);
    int t = 0;
    bit done = 1'b0;
    while (!done) begin
      step();
      wr_en   = 1'b1;
      wr_data = b;
      clr_ovf = 1'b0;
      if (!full) begin
        push_flag = 1'b1;
        exp_q.push_back(b);
        done = 1'b1;
      end else begin
        push_flag = 1'b0;
        t++;
        if (t > 500) begin
          chk("push_retry_timeout", 32'(full), 32'd0);
          done = 1'b1;
        end
      end
    end
  endtask

  task automatic wait_drain(input int limit);
    int t = 0;
    while (exp_q.size() != 0 && t < limit) begin
      step();
      wr_en     = 1'b0;
      push_flag = 1'b0;
      clr_ovf   = 1'b0;
      t++;
    end
    chk("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_not_busy(input int limit);
    int t = 0;
    while (tx_busy && t < limit) begin
      idle(1);
      t++;
    end
    chk("busy_release", 32'(tx_busy), 32'd0);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_tx_we", 32'(tx_we), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'h00);
    rst_n = 1'b1;

    // Idle after reset.
    idle(20);
    chk("idle_tx_data", 32'(tx_data), 32'h00);
    chk("idle_we_total", 32'(we_total), 32'd0);

    // Single byte with a long busy period.
    busy_len = 40;
    push_retry(8'h41);
    wait_drain(20);
    idle(50);
    chk("single_count", 32'(count), 32'd0);
    chk("single_we_total", 32'(we_total), 32'd1);
    wait_not_busy(60);

    // Primer byte holds the FSM in WAIT_DONE while a 16-byte burst fills the FIFO.
    busy_len    = 60;
    last_we_cyc = -1;
    gap_chk     = 1'b1;
    push_retry(8'h0E);
    wait_drain(10);
    busy_len = 5;
    for (int i = 0; i < 16; i++) push_retry(8'(8'h10 + i));
    step();
    wr_en     = 1'b1;
    wr_data   = 8'hAA;
    push_flag = 1'b0;
    idle(1);
    chk("burst_full", 32'(full), 32'd1);
    chk("burst_count", 32'(count), 32'd16);
    chk("burst_ovf_set", 32'(overflow), 32'd1);
    step();
    clr_ovf = 1'b1;
    idle(1);
    chk("burst_ovf_clr", 32'(overflow), 32'd0);
    wait_drain(16 * 9 + 100);
    gap_chk = 1'b0;
    wait_not_busy(20);
    idle(5);

    // Streaming with pushes every cycle while the FIFO drains. Pointers wrap several times.
    busy_len = 10;
    for (int i = 0; i < 40; i++) push_retry(8'(8'h80 + i));
    wait_drain(40 * 14 + 100);
    wait_not_busy(20);
    idle(5);

    // Transmitter never goes busy, so the start timeout abandons each byte.
    busy_len    = 0;
    last_we_cyc = -1;
    gap_chk     = 1'b1;
    push_retry(8'h55);
    push_retry(8'h56);
    wait_drain(30);
    idle(10);
    gap_chk = 1'b0;
    chk("tmo_tx_data_hold", 32'(tx_data), 32'h56);
    chk("tmo_count", 32'(count), 32'd0);

    // Asynchronous reset while in WAIT_DONE with five bytes queued.
    busy_len = 40;
    for (int i = 0; i < 6; i++) push_retry(8'(8'h60 + i));
    idle(10);
    chk("prerst_count", 32'(count), 32'd5);
    chk("prerst_busy", 32'(tx_busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_empty", 32'(empty), 32'd1);
    chk("arst_full", 32'(full), 32'd0);
    chk("arst_tx_we", 32'(tx_we), 32'd0);
    chk("arst_tx_data", 32'(tx_data), 32'h00);
    chk("arst_ovf", 32'(overflow), 32'd0);
    exp_q.delete();
    model_cnt = 0;
    push_flag = 1'b0;
    edge_push = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    wait_not_busy(60);
    idle(10);
    chk("post_rst_count", 32'(count), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_serial_tx_fifo

// File: doc/serial_tx_fifo.md
Name: serial_tx_fifo

Overview:
- Byte FIFO plus issue FSM sitting directly upstream of the UART transmitter (send_serial); producers (CPU store path, debug logger) push bytes at clock rate.
- Block hands each byte to the transmitter with a one-cycle tx_we pulse, then waits for the transmitter's busy to rise and fall before issuing the next byte.
- Decouples bursty writers from the 10-bit-per-byte serial rate.

Parameters:
- DEPTH, 16, FIFO entries; power of two, >= 2.
- START_TMO, 4, max cycles to wait for tx_busy to rise after a tx_we pulse before abandoning the wait.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- wr_data  in  8  byte to enqueue.
- wr_en  in  1  push request; accepted when not full.
- full  out  1  FIFO holds DEPTH entries (combinational from count).
- empty  out  1  FIFO holds 0 entries (combinational from count).
- count  out  $clog2(DEPTH)+1  current occupancy.
- overflow  out  1  sticky: a push was attempted while full.
- clr_ovf  in  1  clears overflow.
- tx_data  out  8  byte presented to the transmitter; registered, stable from issue until the next issue.
- tx_we  out  1  one-cycle issue strobe to the transmitter.
- tx_busy  in  1  transmitter busy flag.

Behaviour:
- Reset (rst_n low, async): rd_ptr=wr_ptr=0, count=0, overflow=0, tx_data=8'h00, tx_we=0, FSM=IDLE. Consequently empty=1, full=0.
- Storage: DEPTH x 8 register array. Pointers are $clog2(DEPTH) bits and wrap naturally modulo DEPTH. Occupancy tracked by a separate count register, never derived from pointer difference.
- Push: wr_en && !full writes mem[wr_ptr] and increments wr_ptr.
  - wr_en && full: data is dropped, pointers unchanged, overflow<=1.
- Pop: occurs only on the FSM IDLE->ISSUE transition. tx_data<=mem[rd_ptr] and rd_ptr increments.
- Count: push only +1; pop only -1; push and pop in the same cycle leave count unchanged.
  - Push while full is refused even if a pop happens in the same cycle; the writer retries next cycle.
- Overflow: clr_ovf clears it. clr_ovf coinciding with a new overflow event leaves overflow=1 (set wins).
- FSM (enum IDLE, ISSUE, WAIT_START, WAIT_DONE):
  - IDLE: if !empty, pop into tx_data and go to ISSUE; else stay.
  - ISSUE: tx_we=1 for exactly this cycle (registered output); go to WAIT_START and clear tmo_cnt.
  - WAIT_START: if tx_busy=1, go to WAIT_DONE. Otherwise increment tmo_cnt; when tmo_cnt==START_TMO-1, go to IDLE (the byte is considered lost; no retry).
  - WAIT_DONE: when tx_busy=0, go to IDLE.
- Throughput: byte issued to the first empty-check of the next byte = transmitter busy time + 3 cycles. An empty->first tx_we latency is 2 cycles after the push edge (push visible at edge N, IDLE sees !empty, ISSUE at N+1, tx_we high during N+2 cycle).
- tx_we is never asserted while tx_busy=1 and never on consecutive cycles.
- Reset mid-transmission: all FIFO content is discarded. The transmitter owns its own reset, so no handshake recovery is needed here.

Decomposition:
- Package serial_pkg holds typedef enum tx_fifo_state_t {IDLE, ISSUE, WAIT_START, WAIT_DONE}. The package also holds localparam BYTE_W=8, which is shared with send_serial and the future receiver.
- One natural sub-module: sync_fifo (storage, pointers, count, full/empty, overflow). serial_tx_fifo instantiates it and adds the issue FSM.

Test Plan:
- Reset then idle 20 cycles -> empty=1, count=0, tx_we never asserted, tx_data=8'h00.
- Push 8'h41 into empty FIFO, with the bench modelling tx_busy high for 40 cycles starting the cycle after tx_we -> one tx_we pulse with tx_data=8'h41; count returns to 0; no second pulse.
- Push 8'h10..8'h1F back-to-back (16 bytes) -> full=1 after the 16th; a 17th push 8'hAA sets overflow and is dropped. The transmit order observed is 8'h10..8'h1F exactly; clr_ovf then clears overflow.
- Push every cycle while the FIFO drains with a busy model of 10 cycles -> simultaneous push/pop cycles leave count unchanged. Pointers wrap past index 15 with correct byte order over 40 bytes.
- tx_busy held low forever after push 8'h55 -> tx_we once, return to IDLE after START_TMO=4 cycles. The next queued byte 8'h56 is issued afterwards.
- Assert rst_n low asynchronously mid-WAIT_DONE with count=5 -> outputs take reset values immediately (before the next clock edge) and count=0.
